mips_decode_queue: RTL and testbench
====================================

Name: mips_decode_queue

Overview:
- Registered, parametrised MIPS instruction decode stage between the fetch unit and the execute/control logic.
- Each accepted 32-bit instruction is decoded into a one-hot instruction-class vector and extracted register/immediate fields.
- Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Replaces the purely combinational class decoder; full opcode+funct (and REGIMM rt) decoding is done here.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, 2..8.
- NUM_OPS, 11, width of one-hot class vector; fixed by package constant, not to be overridden.
- CNT_W, 16, width of the decoded-instruction counter; saturates.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- flush  in  1  synchronous queue clear (branch/jump redirect).
- in_valid  in  1  instr is valid.
- in_ready  out  1  queue can accept this cycle.
- instr  in  32  raw instruction word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head this cycle.
- out_op  out  NUM_OPS  one-hot class: bit0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 bgezal, 8 jal, 9 j, 10 jr.
- out_rs  out  5  instr[25:21].
- out_rt  out  5  instr[20:16].
- out_rd  out  5  instr[15:11].
- out_imm  out  16  instr[15:0].
- out_jidx  out  26  instr[25:0].
- dec_count  out  CNT_W  instructions accepted since reset.

Behaviour:
- Encodings, op=instr[31:26], fn=instr[5:0]:
  - addu: op 000000, fn 100001
  - subu: op 000000, fn 100011
  - jr: op 000000, fn 001000
  - ori: op 001101
  - lw: op 100011
  - sw: op 101011
  - beq: op 000100
  - lui: op 001111
  - jal: op 000011
  - j: op 000010
  - bgezal: op 000001 with rt 10001
  - Any other word: out_op all zero.
- At most one out_op bit is set.
- Accept = in_valid & in_ready. Decode is combinational on instr; the entry is written on the accepting edge.
- in_ready = !full. No pass-through: when full, in_ready stays low even if out_ready is high.
- out_valid = !empty. out_* show the head entry; pop = out_valid & out_ready.
- Latency: an instruction accepted at edge N is visible with out_valid=1 after edge N (zero-bubble when the queue was empty).
- Push and pop in the same cycle: both happen, occupancy unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. An occupancy counter of log2(DEPTH)+1 bits gives full/empty.
- dec_count increments on every accept, saturates at all-ones, and is not cleared by flush.
- flush=1:
  - Next edge empties the queue (pointers and occupancy to 0).
  - A push in the same cycle is discarded. in_ready is forced low while flush=1 so upstream does not count it as taken.
  - A pop in the same cycle is ignored.
- Reset (rst_n=0 at an edge), including mid-stream: pointers, occupancy and dec_count go to 0.
- Reset output values: out_valid=0, in_ready=1 from the first cycle after reset.
- Storage is not reset. out_op/fields are don't-care while out_valid=0, but out_op must read 0 when out_valid=0; gate it.

Optional Feature:
- Macro: MIPS_DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds ports out_illegal (out, 1) and illegal_seen (out, 1).
  - out_illegal is stored per entry and is 1 when the decoded out_op is zero.
  - illegal_seen is sticky. It is set on accepting an illegal word and cleared only by reset (not by flush); reset value 0.
- Undefined: neither port exists, and illegal words pass through with out_op=0.

Decomposition:
- Package mips_decode_pkg holds:
  - opcode/funct/REGIMM-rt localparams
  - one-hot bit index constants OP_ADDU..OP_JR
  - NUM_OPS=11
  - a struct/packed bundle for the decoded entry (op, rs, rt, rd, imm, jidx, optional illegal)
- Sub-module mips_op_classify: pure combinational instr -> one-hot (+illegal).
- The FIFO and counters stay in the top.

Test Plan:
- Reset, then push 0x00221821 (addu $3,$1,$2) → next cycle out_valid=1, out_op=0x001, rs=1, rt=2, rd=3; dec_count=1.
- Stream 0x34011234, 0x8C020004, 0x04310003, 0x03E00008 with out_ready=1 → out_op 0x004, 0x008, 0x080, 0x400 in order; ori imm=0x1234; bgezal rt=17.
- out_ready=0, push DEPTH+1 words → in_ready=0 after DEPTH accepts. Then pop/push simultaneously → occupancy holds at DEPTH-1 and order is preserved across pointer wrap.
- Fill 2 entries, assert flush with in_valid=1 → out_valid=0 next cycle, the pushed word is lost, dec_count unchanged by the flushed word.
- Push 0xFC000000 → out_op=0. With MIPS_DECODE_ILLEGAL_TRAP_EN, out_illegal=1 and illegal_seen stays 1 through a flush, clearing only on rst_n=0.
- Pulse rst_n=0 with 3 entries queued and in_valid high → out_valid=0, in_ready=1, dec_count=0 the cycle after release.

Source files
------------

// File: rtl/mips_decode_pkg.sv
// rtl/mips_decode_pkg.sv - MIPS decode encodings and entry type (MIPS_DECODE_ILLEGAL_TRAP_EN adds illegal flag)
package mips_decode_pkg;

    localparam int NUM_OPS = 11;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_REGIMM  = 6'b000001;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam int OP_ADDU   = 0;
    localparam int OP_SUBU   = 1;
    localparam int OP_ORI    = 2;
    localparam int OP_LW     = 3;
    localparam int OP_SW     = 4;
    localparam int OP_BEQ    = 5;
    localparam int OP_LUI    = 6;
    localparam int OP_BGEZAL = 7;
    localparam int OP_JAL    = 8;
    localparam int OP_J      = 9;
    localparam int OP_JR     = 10;

    typedef struct packed {
        logic [NUM_OPS-1:0] op;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         rd;
        logic [15:0]        imm;
        logic [25:0]        jidx;
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
        logic               illegal;
`endif
    } dec_entry_t;

endpackage

// File: rtl/mips_op_classify.sv
// rtl/mips_op_classify.sv - combinational instr to one-hot class (illegal output under MIPS_DECODE_ILLEGAL_TRAP_EN)
module mips_op_classify
    import mips_decode_pkg::*;
(
    input  logic [31:0]        instr,
    output logic [NUM_OPS-1:0] op
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
    ,
    output logic               illegal
`endif
);

    logic [5:0] opc;
    logic [5:0] fn;
    logic [4:0] rt;

    assign opc = instr[31:26];
    assign fn  = instr[5:0];
    assign rt  = instr[20:16];

    always_comb begin
        op = '0;
        case (opc)
            OPC_SPECIAL: begin
                case (fn)
                    FN_ADDU: op[OP_ADDU] = 1'b1;
                    FN_SUBU: op[OP_SUBU] = 1'b1;
                    FN_JR:   op[OP_JR]   = 1'b1;
                    default: op = '0;
                endcase
            end
            OPC_REGIMM: op[OP_BGEZAL] = (rt == RT_BGEZAL);
            OPC_ORI:    op[OP_ORI]    = 1'b1;
            OPC_LW:     op[OP_LW]     = 1'b1;
            OPC_SW:     op[OP_SW]     = 1'b1;
            OPC_BEQ:    op[OP_BEQ]    = 1'b1;
            OPC_LUI:    op[OP_LUI]    = 1'b1;
            OPC_JAL:    op[OP_JAL]    = 1'b1;
            OPC_J:      op[OP_J]      = 1'b1;
            default:    op = '0;
        endcase
    end

`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
    assign illegal = (op == '0);
`endif

endmodule

// File: rtl/mips_decode_queue.sv
// rtl/mips_decode_queue.sv - registered MIPS decode stage with output FIFO (MIPS_DECODE_ILLEGAL_TRAP_EN adds illegal trap)
module mips_decode_queue
    import mips_decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OPS-1:0] out_op,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [15:0]        out_imm,
    output logic [25:0]        out_jidx,
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
    output logic               out_illegal,
    output logic               illegal_seen,
`endif
    output logic [CNT_W-1:0]   dec_count
);

    localparam int AW = $clog2(DEPTH);

    dec_entry_t         mem [DEPTH];
    dec_entry_t         wr_entry;
    dec_entry_t         head;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        occ;
    logic               full;
    logic               push;
    logic               pop;
    logic [NUM_OPS-1:0] cls_op;
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
    logic               cls_illegal;
`endif

    mips_op_classify u_classify (
        .instr   (instr),
        .op      (cls_op)
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
        ,
        .illegal (cls_illegal)
`endif
    );

    always_comb begin
        wr_entry      = '0;
        wr_entry.op   = cls_op;
        wr_entry.rs   = instr[25:21];
        wr_entry.rt   = instr[20:16];
        wr_entry.rd   = instr[15:11];
        wr_entry.imm  = instr[15:0];
        wr_entry.jidx = instr[25:0];
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
        wr_entry.illegal = cls_illegal;
`endif
    end

    assign full      = (occ == (AW+1)'(DEPTH));
    // flush drops in_ready so upstream never believes a discarded word was taken
    assign in_ready  = !full && !flush;
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            dec_count <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
            end
            if (push && (dec_count != '1)) dec_count <= dec_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head     = mem[rd_ptr];
    assign out_op   = out_valid ? head.op : '0;
    assign out_rs   = head.rs;
    assign out_rt   = head.rt;
    assign out_rd   = head.rd;
    assign out_imm  = head.imm;
    assign out_jidx = head.jidx;

`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
    assign out_illegal = head.illegal;

    always_ff @(posedge clk) begin
        if (!rst_n)                   illegal_seen <= 1'b0;
        else if (push && cls_illegal) illegal_seen <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mips_decode_queue.sv
// tb/tb_mips_decode_queue.sv - randomized bench for mips_decode_queue against a queue model (MIPS_DECODE_ILLEGAL_TRAP_EN aware)
module tb_mips_decode_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             out_valid;
    logic             out_ready;
    logic [10:0]      out_op;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_rd;
    logic [15:0]      out_imm;
    logic [25:0]      out_jidx;
    logic [CNT_W-1:0] dec_count;
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
    logic             out_illegal;
    logic             illegal_seen;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] q [$];
    int          m_cnt;
    bit          m_seen;

    mips_decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_imm      (out_imm),
        .out_jidx     (out_jidx),
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
        .out_illegal  (out_illegal),
        .illegal_seen (illegal_seen),
`endif
        .dec_count    (dec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // class table: bit i set when (word & mask[i]) == match[i]
    function automatic logic [10:0] ref_op(input logic [31:0] w);
        logic [31:0] mask [11] = '{32'hFC00003F, 32'hFC00003F, 32'hFC000000, 32'hFC000000,
                                   32'hFC000000, 32'hFC000000, 32'hFC000000, 32'hFC1F0000,
                                   32'hFC000000, 32'hFC000000, 32'hFC00003F};
        logic [31:0] match [11] = '{32'h00000021, 32'h00000023, 32'h34000000, 32'h8C000000,
                                    32'hAC000000, 32'h10000000, 32'h3C000000, 32'h04110000,
                                    32'h0C000000, 32'h08000000, 32'h00000008};
        logic [10:0] r = '0;
        for (int i = 0; i < 11; i++)
            if (((w & mask[i]) == match[i]) && (r == '0)) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 12))
            0:  begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
            1:  begin r[31:26] = 6'h00; r[5:0] = 6'h23; end
            2:  begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
            3:  r[31:26] = 6'h0D;
            4:  r[31:26] = 6'h23;
            5:  r[31:26] = 6'h2B;
            6:  r[31:26] = 6'h04;
            7:  r[31:26] = 6'h0F;
            8:  r[31:26] = 6'h03;
            9:  r[31:26] = 6'h02;
            10: begin r[31:26] = 6'h01; r[20:16] = 5'h11; end
            11: r[31:26] = 6'h01;
            default: ;
        endcase
        return r;
    endfunction

    // called just after a negedge; returns just after the following negedge
    task automatic cycle(input bit v, input logic [31:0] w, input bit r, input bit f);
        bit exp_rdy, exp_vld, acc, pop;
        logic [31:0] h;
        rst_n = 1'b1; in_valid = v; instr = w; out_ready = r; flush = f;
        #1;
        exp_rdy = !f && (q.size() < DEPTH);
        exp_vld = q.size() > 0;
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, exp_vld);
        check("onehot", ($countones(out_op) <= 1), 1);
        if (exp_vld) begin
            h = q[0];
            check("out_op", out_op, ref_op(h));
            check("out_rs", out_rs, h[25:21]);
            check("out_rt", out_rt, h[20:16]);
            check("out_rd", out_rd, h[15:11]);
            check("out_imm", out_imm, h[15:0]);
            check("out_jidx", out_jidx, h[25:0]);
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
            check("out_illegal", out_illegal, ref_op(h) == '0);
`endif
        end else begin
            check("out_op_idle", out_op, 0);
        end
        acc = v && exp_rdy;
        pop = exp_vld && r;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(w);
        end
        if (acc) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (ref_op(w) == '0) m_seen = 1'b1;
        end
        @(negedge clk);
        check("dec_count", dec_count, m_cnt);
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
        check("illegal_seen", illegal_seen, m_seen);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b1; instr = 32'h00221821; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        q.delete(); m_cnt = 0; m_seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_dec_count", dec_count, 0);
        check("rst_out_op", out_op, 0);
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
        check("rst_illegal_seen", illegal_seen, 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
        m_cnt = 0; m_seen = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        cycle(1, 32'h00221821, 0, 0);
        check("addu_op", out_op, 11'h001);
        check("addu_rs", out_rs, 1);
        check("addu_rt", out_rt, 2);
        check("addu_rd", out_rd, 3);
        check("addu_cnt", dec_count, 1);
        cycle(0, 0, 1, 0);

        cycle(1, 32'h34011234, 1, 0);
        check("ori_op", out_op, 11'h004);
        check("ori_imm", out_imm, 16'h1234);
        cycle(1, 32'h8C020004, 1, 0);
        check("lw_op", out_op, 11'h008);
        cycle(1, 32'h04310003, 1, 0);
        check("bgezal_op", out_op, 11'h080);
        check("bgezal_rt", out_rt, 17);
        cycle(1, 32'h03E00008, 1, 0);
        check("jr_op", out_op, 11'h400);
        cycle(0, 0, 1, 0);

        for (int i = 0; i <= DEPTH; i++) cycle(1, rand_instr(), 0, 0);
        check("full_in_ready", in_ready, 0);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 3 * DEPTH; i++) cycle(1, rand_instr(), 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 0);

        do_reset();
        cycle(1, 32'h3C01ABCD, 0, 0);
        cycle(1, 32'hAC220008, 0, 0);
        cycle(1, 32'h10220004, 0, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_cnt", dec_count, 2);
        cycle(0, 0, 1, 0);

        cycle(1, 32'hFC000000, 0, 0);
        check("illegal_op", out_op, 0);
        check("illegal_valid", out_valid, 1);
`ifdef MIPS_DECODE_ILLEGAL_TRAP_EN
        check("illegal_flag", out_illegal, 1);
        cycle(0, 0, 0, 1);
        check("seen_after_flush", illegal_seen, 1);
`endif

        for (int i = 0; i < 3; i++) cycle(1, rand_instr(), 0, 0);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                       $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
